// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage: default widths, default
// fetch queue depth and the queue entry format ({pc, inst}).
//
// Compile-time defaults (overridable on the command line):
//   `FQ_DEPTH   default fetch queue depth (power of two, >= 2)
//   `AddrWidth  default address width
//   `InstWidth  default instruction width
// -----------------------------------------------------------------------------
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif

`ifndef AddrWidth
`define AddrWidth 32
`endif

`ifndef InstWidth
`define InstWidth 32
`endif

package fetch_stage_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = `AddrWidth;
    localparam int unsigned INST_WIDTH_DEF = `InstWidth;
    localparam int unsigned FQ_DEPTH_DEF   = `FQ_DEPTH;

    // Queue entry at the default widths; fetch_stage builds an equivalent
    // entry type from its own ADDR/INST parameters.
    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] pc;
        logic [INST_WIDTH_DEF-1:0] inst;
    } FetchQEntry_t;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fetch_stage_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Generic synchronous FIFO with clear. Push and pop in the same cycle are
// allowed at any occupancy, including full (the popped slot frees room for the
// pushed word). Push while full without pop, and pop while empty, are ignored.
// rdata_o always shows the head slot; after reset the storage is all zeros.
//
// Ports:
//   clk, reset_         clock, asynchronous active-low reset
//   clr_i               drop all entries (takes priority over push/pop)
//   push_i, wdata_i     write wdata_i at the tail
//   pop_i               advance the head
//   rdata_o             head entry
//   full_o, empty_o     occupancy flags
//   count_o             number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
)(
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          clr_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              wdata_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule : fetch_queue

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage between the icache and decode. Generates sequential
// fetch PCs, issues requests under credit-based flow control, buffers returned
// instructions in an in-order queue and presents them to decode. A redirect
// from the back end flushes the icache, the queue and the in-flight count and
// reloads the PC.
//
// Build option:
//   FETCH_BYPASS_EN  when defined, a response arriving at an empty queue is
//                    presented to decode in the same cycle (consumed without
//                    being written if decode is not stalled). When undefined,
//                    every response goes through the queue (1-cycle latency).
//
// Ports:
//   clk, reset_                       clock, asynchronous active-low reset
//   ic_e_, ic_pc, ic_inst             icache response (valid active-low)
//   ic_stall_                         low = icache cannot accept a request
//   fetch_e_, fetch_pc                request to icache (valid active-low)
//   flush_                            low = icache drops in-flight requests
//   dec_stall                         high = decode does not consume
//   inst_e_, inst_pc, inst            instruction to decode (valid active-low)
//   redirect_e_, redirect_pc          redirect from back end (active-low)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     ADDR     = ADDR_WIDTH_DEF,
    parameter int unsigned     INST     = INST_WIDTH_DEF,
    parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEF,
    parameter logic [ADDR-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            reset_,
    input  logic            ic_e_,
    input  logic [ADDR-1:0] ic_pc,
    input  logic [INST-1:0] ic_inst,
    input  logic            ic_stall_,
    output logic            fetch_e_,
    output logic [ADDR-1:0] fetch_pc,
    output logic            flush_,
    input  logic            dec_stall,
    output logic            inst_e_,
    output logic [ADDR-1:0] inst_pc,
    output logic [INST-1:0] inst,
    input  logic            redirect_e_,
    input  logic [ADDR-1:0] redirect_pc
);

    localparam int unsigned     CW      = cnt_width(FQ_DEPTH);
    localparam int unsigned     SW      = CW + 1;
    localparam logic [ADDR-1:0] PC_STEP = ADDR'(INST / 8);

    typedef struct packed {
        logic [ADDR-1:0] pc;
        logic [INST-1:0] inst;
    } fq_entry_t;

    logic [ADDR-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;

    logic            redirect;
    logic            resp;
    logic            credit;
    logic            req_valid;
    logic            accept;
    logic [SW-1:0]   inflight;

    logic            q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]   q_count;
    fq_entry_t       q_wdata, q_rdata;

    assign redirect = ~redirect_e_;
    // A response in the redirect cycle belongs to the old path and is dropped.
    assign resp     = ~ic_e_ & ~redirect;

    // Queued entries plus requests still owed by the icache must fit in the
    // queue, so every response always has a slot.
    assign inflight = SW'(q_count) + SW'(outst_q);
    assign credit   = ~q_full & (inflight < SW'(FQ_DEPTH));

    // reset_ gates the request so fetch_e_ reads idle while reset is held.
    assign req_valid = reset_ & credit & ~redirect;
    assign accept    = req_valid & ic_stall_;

    assign fetch_e_ = ~req_valid;
    assign fetch_pc = pc_q;
    assign flush_   = redirect_e_;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (accept) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (redirect) begin
            outst_d = '0;
        end else begin
            case ({accept, ~ic_e_})
                2'b10:   outst_d = outst_q + CW'(1);
                2'b01:   outst_d = outst_q - CW'(1);
                default: outst_d = outst_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
        end
    end

    assign q_wdata.pc   = ic_pc;
    assign q_wdata.inst = ic_inst;
    assign q_pop        = ~q_empty & ~dec_stall & ~redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;

    assign bypass  = q_empty & resp;
    // A bypassed response that decode takes this cycle never enters the queue.
    assign q_push  = resp & ~(bypass & ~dec_stall);
    assign inst_e_ = ~((~q_empty | bypass) & ~redirect);
    assign inst_pc = bypass ? ic_pc   : q_rdata.pc;
    assign inst    = bypass ? ic_inst : q_rdata.inst;
`else
    assign q_push  = resp;
    assign inst_e_ = q_empty | redirect;
    assign inst_pc = q_rdata.pc;
    assign inst    = q_rdata.inst;
`endif

    fetch_queue #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .reset_  (reset_),
        .clr_i   (redirect),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .wdata_i (q_wdata),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_;
    logic        ic_e_, ic_stall_, dec_stall, redirect_e_;
    logic [31:0] ic_pc, ic_inst, redirect_pc;
    logic        fetch_e_, flush_, inst_e_;
    logic [31:0] fetch_pc, inst_pc, inst;

    logic        q_clr, q_push, q_pop, q_full, q_empty;
    logic [7:0]  q_wd, q_rd;
    logic [2:0]  q_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR     (32),
        .INST     (32),
        .FQ_DEPTH (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .ic_e_       (ic_e_),
        .ic_pc       (ic_pc),
        .ic_inst     (ic_inst),
        .ic_stall_   (ic_stall_),
        .fetch_e_    (fetch_e_),
        .fetch_pc    (fetch_pc),
        .flush_      (flush_),
        .dec_stall   (dec_stall),
        .inst_e_     (inst_e_),
        .inst_pc     (inst_pc),
        .inst        (inst),
        .redirect_e_ (redirect_e_),
        .redirect_pc (redirect_pc)
    );

    fetch_queue #(.WIDTH(8), .DEPTH(4)) u_q (
        .clk     (clk),
        .reset_  (reset_),
        .clr_i   (q_clr),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .wdata_i (q_wd),
        .rdata_o (q_rd),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_cnt)
    );

    // One record per cycle: inputs, then expected outputs.
    // redir/resp/icstall/dec are "asserted" flags; fv/fl/iv are expected
    // request-valid / flush-active / instruction-valid.
    typedef struct {
        bit          redir;
        logic [31:0] rpc;
        bit          resp;
        logic [31:0] rsp_pc;
        bit          icstall;
        bit          dec;
        bit          fv;
        logic [31:0] fpc;
        bit          fl;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs[NV];

    function automatic vec_t mk(bit redir, logic [31:0] rpc, bit resp, logic [31:0] rsp_pc,
                                bit icstall, bit dec, bit fv, logic [31:0] fpc, bit fl,
                                bit iv, logic [31:0] ipc);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.resp = resp; v.rsp_pc = rsp_pc;
        v.icstall = icstall; v.dec = dec; v.fv = fv; v.fpc = fpc; v.fl = fl;
        v.iv = iv; v.ipc = ipc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic qcyc(input bit c, input bit p, input bit o, input logic [7:0] d);
        q_clr = c; q_push = p; q_pop = o; q_wd = d;
        @(negedge clk);
        #1;
        q_clr = 1'b0; q_push = 1'b0; q_pop = 1'b0; q_wd = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        //            redir rpc           resp rsp_pc       ics dec  fv fpc           fl iv ipc
        vecs[0]  = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'h0,         0, 0, 32'h0);
        vecs[1]  = mk(0, 32'h0,         1, 32'h0,         0, 0,   1, 32'h4,         0, 0, 32'h0);
        vecs[2]  = mk(0, 32'h0,         1, 32'h4,         0, 0,   1, 32'h8,         0, 1, 32'h0);
        vecs[3]  = mk(0, 32'h0,         1, 32'h8,         0, 0,   1, 32'hC,         0, 1, 32'h4);
        vecs[4]  = mk(0, 32'h0,         1, 32'hC,         0, 1,   1, 32'h10,        0, 1, 32'h8);
        vecs[5]  = mk(0, 32'h0,         1, 32'h10,        0, 1,   1, 32'h14,        0, 1, 32'h8);
        vecs[6]  = mk(0, 32'h0,         1, 32'h14,        0, 1,   0, 32'h18,        0, 1, 32'h8);
        vecs[7]  = mk(0, 32'h0,         0, 32'h0,         0, 1,   0, 32'h18,        0, 1, 32'h8);
        vecs[8]  = mk(0, 32'h0,         0, 32'h0,         0, 1,   0, 32'h18,        0, 1, 32'h8);
        vecs[9]  = mk(0, 32'h0,         0, 32'h0,         0, 0,   0, 32'h18,        0, 1, 32'h8);
        vecs[10] = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'h18,        0, 1, 32'hC);
        vecs[11] = mk(0, 32'h0,         1, 32'h18,        1, 0,   1, 32'h1C,        0, 1, 32'h10);
        vecs[12] = mk(0, 32'h0,         0, 32'h0,         1, 0,   1, 32'h1C,        0, 1, 32'h14);
        vecs[13] = mk(0, 32'h0,         0, 32'h0,         1, 0,   1, 32'h1C,        0, 1, 32'h18);
        vecs[14] = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'h1C,        0, 0, 32'h0);
        vecs[15] = mk(0, 32'h0,         1, 32'h1C,        0, 0,   1, 32'h20,        0, 0, 32'h0);
        vecs[16] = mk(0, 32'h0,         0, 32'h0,         0, 1,   1, 32'h24,        0, 1, 32'h1C);
        vecs[17] = mk(0, 32'h0,         0, 32'h0,         0, 1,   1, 32'h28,        0, 1, 32'h1C);
        vecs[18] = mk(0, 32'h0,         0, 32'h0,         0, 1,   0, 32'h2C,        0, 1, 32'h1C);
        vecs[19] = mk(0, 32'h0,         1, 32'h20,        0, 1,   0, 32'h2C,        0, 1, 32'h1C);
        vecs[20] = mk(0, 32'h0,         1, 32'h24,        0, 1,   0, 32'h2C,        0, 1, 32'h1C);
        vecs[21] = mk(1, 32'h100,       1, 32'h28,        0, 0,   0, 32'h2C,        1, 0, 32'h0);
        vecs[22] = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'h100,       0, 0, 32'h0);
        vecs[23] = mk(0, 32'h0,         1, 32'h100,       0, 0,   1, 32'h104,       0, 0, 32'h0);
        vecs[24] = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'h108,       0, 1, 32'h100);
        vecs[25] = mk(1, 32'h200,       1, 32'h104,       0, 0,   0, 32'h10C,       1, 0, 32'h0);
        vecs[26] = mk(1, 32'h300,       0, 32'h0,         0, 0,   0, 32'h200,       1, 0, 32'h0);
        vecs[27] = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'h300,       0, 0, 32'h0);
        vecs[28] = mk(1, 32'hFFFFFFFC,  1, 32'h300,       0, 0,   0, 32'h304,       1, 0, 32'h0);
        vecs[29] = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'hFFFFFFFC,  0, 0, 32'h0);
        vecs[30] = mk(0, 32'h0,         1, 32'hFFFFFFFC,  0, 0,   1, 32'h0,         0, 0, 32'h0);
        vecs[31] = mk(0, 32'h0,         0, 32'h0,         0, 0,   1, 32'h4,         0, 1, 32'hFFFFFFFC);

        reset_      = 1'b0;
        ic_e_       = 1'b1;
        ic_pc       = '0;
        ic_inst     = '0;
        ic_stall_   = 1'b1;
        dec_stall   = 1'b0;
        redirect_e_ = 1'b1;
        redirect_pc = '0;
        q_clr = 1'b0; q_push = 1'b0; q_pop = 1'b0; q_wd = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        chk("reset fetch_e_", {31'd0, fetch_e_}, 32'd1);
        chk("reset fetch_pc", fetch_pc, 32'h0);
        chk("reset flush_",   {31'd0, flush_}, 32'd1);
        chk("reset inst_e_",  {31'd0, inst_e_}, 32'd1);
        chk("reset inst_pc",  inst_pc, 32'h0);
        chk("reset inst",     inst, 32'h0);

        @(negedge clk);
        reset_ = 1'b1;

        for (int i = 0; i < NV; i++) begin
            redirect_e_ = ~vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            ic_e_       = ~vecs[i].resp;
            ic_pc       = vecs[i].rsp_pc;
            ic_inst     = vecs[i].rsp_pc + 32'h1000;
            ic_stall_   = ~vecs[i].icstall;
            dec_stall   = vecs[i].dec;
            #1;
            chk($sformatf("v%0d fetch_e_", i), {31'd0, fetch_e_}, {31'd0, ~vecs[i].fv});
            chk($sformatf("v%0d fetch_pc", i), fetch_pc, vecs[i].fpc);
            chk($sformatf("v%0d flush_", i),   {31'd0, flush_},   {31'd0, ~vecs[i].fl});
            chk($sformatf("v%0d inst_e_", i),  {31'd0, inst_e_},  {31'd0, ~vecs[i].iv});
            if (vecs[i].iv) begin
                chk($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].ipc);
                chk($sformatf("v%0d inst", i),    inst,    vecs[i].ipc + 32'h1000);
            end
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle with live state.
        redirect_e_ = 1'b1;
        ic_e_       = 1'b1;
        ic_stall_   = 1'b1;
        dec_stall   = 1'b0;
        #2;
        reset_ = 1'b0;
        #1;
        chk("midrst fetch_pc", fetch_pc, 32'h0);
        chk("midrst fetch_e_", {31'd0, fetch_e_}, 32'd1);
        chk("midrst inst_e_",  {31'd0, inst_e_}, 32'd1);
        chk("midrst flush_",   {31'd0, flush_}, 32'd1);
        @(negedge clk);
        reset_ = 1'b1;
        #1;
        chk("postrst fetch_e_", {31'd0, fetch_e_}, 32'd0);
        chk("postrst fetch_pc", fetch_pc, 32'h0);
        @(negedge clk);
        #1;
        chk("postrst next pc", fetch_pc, 32'h4);
        chk("postrst inst_e_", {31'd0, inst_e_}, 32'd1);

        // Queue: fill, push+pop at full, push at full ignored, drain order.
        qcyc(0, 1, 0, 8'h10);
        qcyc(0, 1, 0, 8'h11);
        qcyc(0, 1, 0, 8'h12);
        qcyc(0, 1, 0, 8'h13);
        chk("q fill count", {29'd0, q_cnt}, 32'd4);
        chk("q fill full",  {31'd0, q_full}, 32'd1);
        chk("q fill head",  {24'd0, q_rd}, 32'h10);
        qcyc(0, 1, 1, 8'h14);
        chk("q pushpop full count", {29'd0, q_cnt}, 32'd4);
        chk("q pushpop full head",  {24'd0, q_rd}, 32'h11);
        qcyc(0, 1, 0, 8'h15);
        chk("q overfill count", {29'd0, q_cnt}, 32'd4);
        chk("q overfill head",  {24'd0, q_rd}, 32'h11);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("q drain %0d", k), {24'd0, q_rd}, 32'h11 + k);
            qcyc(0, 0, 1, 8'h00);
        end
        chk("q drained empty", {31'd0, q_empty}, 32'd1);
        chk("q drained count", {29'd0, q_cnt}, 32'd0);
        qcyc(0, 0, 1, 8'h00);
        chk("q underflow count", {29'd0, q_cnt}, 32'd0);
        qcyc(0, 1, 0, 8'h20);
        qcyc(0, 1, 0, 8'h21);
        chk("q refill count", {29'd0, q_cnt}, 32'd2);
        chk("q refill head",  {24'd0, q_rd}, 32'h20);
        qcyc(1, 1, 0, 8'h22);
        chk("q clear empty", {31'd0, q_empty}, 32'd1);
        chk("q clear count", {29'd0, q_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
